stack_ctrl: RTL and testbench

- Initiator-side controller for the team's dual-port stack memory: one read/write port (ind1/in/beta) and one read-only port (ind2).
- Exposes a push/pop/top/pop2 command interface to the datapath and keeps the stack pointer.
- Holds memory addresses stable for a parameterised number of cycles to cover the memory's combinational access delay, then captures read data.
- Sits between the stack unit's control logic and the memory instance.

---
 rtl/stack_ctrl_if.sv | 40 ++++
 rtl/stack_ctrl.sv | 159 +++++++++++++++
 tb/tb_stack_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Command and memory bundle for the stack controller.
// The slave side is the controller itself; the master side is its environment
// (the stack unit's control logic driving commands and the memory instance
// returning read data).
interface stack_ctrl_if #(
    parameter int N        = 1024,
    parameter int M        = 32,
    parameter int IND_SIZE = $clog2(N)
);
    // Command side
    logic                req;
    logic [1:0]          op;
    logic [M-1:0]        dato_in;
    logic                busy;
    logic                done;
    logic                errore;
    logic [M-1:0]        dato_out1;
    logic [M-1:0]        dato_out2;
    logic [IND_SIZE:0]   sp;

    // Memory side
    logic [IND_SIZE-1:0] mem_ind1;
    logic [IND_SIZE-1:0] mem_ind2;
    logic [M-1:0]        mem_in;
    logic                mem_beta;
    logic [M-1:0]        mem_out1;
    logic [M-1:0]        mem_out2;

    modport master (
        output req, op, dato_in, mem_out1, mem_out2,
        input  busy, done, errore, dato_out1, dato_out2, sp,
        input  mem_ind1, mem_ind2, mem_in, mem_beta
    );

    modport slave (
        input  req, op, dato_in, mem_out1, mem_out2,
        output busy, done, errore, dato_out1, dato_out2, sp,
        output mem_ind1, mem_ind2, mem_in, mem_beta
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: accepts PUSH/POP/TOP/POP2 commands, keeps the stack
// pointer, drives a dual-port memory (port 1 read/write, port 2 read-only)
// and holds read addresses for ATTESA cycles before sampling read data.
module stack_ctrl #(
    parameter int N        = 1024,
    parameter int M        = 32,
    parameter int IND_SIZE = $clog2(N),
    parameter int ATTESA   = 8
) (
    input  logic         clock,
    input  logic         reset,
    stack_ctrl_if.slave  bus
);

    localparam int                CW       = $clog2(ATTESA + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(ATTESA - 1);
    localparam logic [IND_SIZE:0] SP_MAX   = (IND_SIZE + 1)'(N);
    localparam logic [IND_SIZE:0] SP_ONE   = (IND_SIZE + 1)'(1);
    localparam logic [IND_SIZE:0] SP_TWO   = (IND_SIZE + 1)'(2);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_TOP  = 2'b10;
    localparam logic [1:0] OP_POP2 = 2'b11;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        SCRIVI         = 2'd1,
        ATTESA_LETTURA = 2'd2,
        FINE           = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [IND_SIZE:0]   sp_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                errore_q;
    logic [M-1:0]        dato_out1_q;
    logic [M-1:0]        dato_out2_q;
    logic [IND_SIZE-1:0] ind1_q;
    logic [IND_SIZE-1:0] ind2_q;
    logic [M-1:0]        in_q;
    logic                beta_q;

    // Pointer arithmetic is one bit wider than an address, then truncated.
    logic [IND_SIZE:0]   sp_m1_s;
    logic [IND_SIZE:0]   sp_m2_s;
    logic                cond_ok_s;

    assign sp_m1_s = sp_q - SP_ONE;
    assign sp_m2_s = sp_q - SP_TWO;

    // Depth check for the command currently on the bus (overflow/underflow).
    always_comb begin
        cond_ok_s = 1'b0;
        case (bus.op)
            OP_PUSH:        cond_ok_s = (sp_q < SP_MAX);
            OP_POP, OP_TOP: cond_ok_s = (sp_q >= SP_ONE);
            OP_POP2:        cond_ok_s = (sp_q >= SP_TWO);
            default:        cond_ok_s = 1'b0;
        endcase
    end

    // Main controller FSM; every output comes straight from a register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            sp_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            errore_q    <= 1'b0;
            dato_out1_q <= '0;
            dato_out2_q <= '0;
            ind1_q      <= '0;
            ind2_q      <= '0;
            in_q        <= '0;
            beta_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        op_q   <= bus.op;
                        busy_q <= 1'b1;
                        if (!cond_ok_s) begin
                            // Rejected: report at once, leave memory signals alone.
                            errore_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= FINE;
                        end else if (bus.op == OP_PUSH) begin
                            ind1_q  <= sp_q[IND_SIZE-1:0];
                            in_q    <= bus.dato_in;
                            beta_q  <= 1'b1;
                            state_q <= SCRIVI;
                        end else begin
                            ind1_q <= sp_m1_s[IND_SIZE-1:0];
                            if (bus.op == OP_POP2) begin
                                ind2_q <= sp_m2_s[IND_SIZE-1:0];
                            end
                            cnt_q   <= '0;
                            state_q <= ATTESA_LETTURA;
                        end
                    end
                end
                SCRIVI: begin
                    // The memory commits the word on this edge.
                    beta_q  <= 1'b0;
                    sp_q    <= sp_q + SP_ONE;
                    done_q  <= 1'b1;
                    state_q <= FINE;
                end
                ATTESA_LETTURA: begin
                    if (cnt_q == CNT_LAST) begin
                        dato_out1_q <= bus.mem_out1;
                        if (op_q == OP_POP2) begin
                            dato_out2_q <= bus.mem_out2;
                        end
                        case (op_q)
                            OP_POP:  sp_q <= sp_m1_s;
                            OP_POP2: sp_q <= sp_m2_s;
                            default: sp_q <= sp_q;
                        endcase
                        done_q  <= 1'b1;
                        state_q <= FINE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FINE: begin
                    done_q   <= 1'b0;
                    errore_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    beta_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.errore    = errore_q;
    assign bus.dato_out1 = dato_out1_q;
    assign bus.dato_out2 = dato_out2_q;
    assign bus.sp        = sp_q;
    assign bus.mem_ind1  = ind1_q;
    assign bus.mem_ind2  = ind2_q;
    assign bus.mem_in    = in_q;
    assign bus.mem_beta  = beta_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed and random commands against a queue-based
// stack model, with a slow dual-port memory model attached.
module tb_stack_ctrl;

    localparam int N      = 4;
    localparam int M      = 8;
    localparam int IW     = 2;
    localparam int ATTESA = 2;
    localparam int DLY    = 12;   // memory read delay, less than two clock periods

    logic clock = 1'b0;
    logic reset;

    stack_ctrl_if #(.N(N), .M(M)) bus ();

    stack_ctrl #(.N(N), .M(M), .ATTESA(ATTESA)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: rising edges at odd times (5, 15, ...)
    always #5 clock = ~clock;

    // Memory model: synchronous write on port 1, delayed combinational reads.
    logic [M-1:0] mem [N] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    time t1 = 0;
    time t2 = 0;

    // Write port
    always @(posedge clock) begin
        if (bus.mem_beta === 1'b1) mem[bus.mem_ind1] <= bus.mem_in;
    end

    // Track the last address change on each port
    always @(bus.mem_ind1) t1 = $time;
    always @(bus.mem_ind2) t2 = $time;

    // Read data is undefined until DLY has elapsed since the address changed
    always begin
        #2;
        bus.mem_out1 = (($time - t1) >= DLY) ? mem[bus.mem_ind1] : 'x;
        bus.mem_out2 = (($time - t2) >= DLY) ? mem[bus.mem_ind2] : 'x;
    end

    // Reference model state
    logic [M-1:0]  stk [$];
    logic [IW-1:0] exp_ind1 = '0;
    logic [IW-1:0] exp_ind2 = '0;
    logic [M-1:0]  exp_in   = '0;
    logic [M-1:0]  exp_d1   = '0;
    logic [M-1:0]  exp_d2   = '0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Stack semantics: decide acceptance, latency and the expected results
    task automatic model_cmd(input logic [1:0] o, input logic [M-1:0] d,
                             output bit ok, output int lat);
        int sp0;
        sp0 = stk.size();
        case (o)
            2'b00:   ok = (sp0 < N);
            2'b11:   ok = (sp0 >= 2);
            default: ok = (sp0 >= 1);
        endcase
        if (!ok) lat = 1;
        else if (o == 2'b00) lat = 2;
        else lat = ATTESA + 1;
        if (ok) begin
            case (o)
                2'b00: begin
                    exp_ind1 = IW'(sp0);
                    exp_in   = d;
                    stk.push_back(d);
                end
                2'b01: begin
                    exp_ind1 = IW'(sp0 - 1);
                    exp_d1   = stk.pop_back();
                end
                2'b10: begin
                    exp_ind1 = IW'(sp0 - 1);
                    exp_d1   = stk[$];
                end
                default: begin
                    exp_ind1 = IW'(sp0 - 1);
                    exp_ind2 = IW'(sp0 - 2);
                    exp_d1   = stk.pop_back();
                    exp_d2   = stk.pop_back();
                end
            endcase
        end
    endtask

    // Issue one command, follow it to done and check everything visible
    task automatic run_cmd(input logic [1:0] o, input logic [M-1:0] d);
        bit ok;
        int lat;
        int n;
        int bc;
        bit seen;
        model_cmd(o, d, ok, lat);
        @(negedge clock);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        bus.req = 1'b1; bus.op = o; bus.dato_in = d;
        n = 0; bc = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) bus.req = 1'b0;
            if (bus.mem_beta === 1'b1) bc++;
            chk("busy_high", 32'(bus.busy), 32'd1);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("latency", seen ? n : 99, 32'(lat));
        chk("errore", 32'(bus.errore), ok ? 32'd0 : 32'd1);
        chk("sp", 32'(bus.sp), 32'(stk.size()));
        chk("dato_out1", 32'(bus.dato_out1), 32'(exp_d1));
        chk("dato_out2", 32'(bus.dato_out2), 32'(exp_d2));
        chk("mem_ind1", 32'(bus.mem_ind1), 32'(exp_ind1));
        chk("mem_ind2", 32'(bus.mem_ind2), 32'(exp_ind2));
        chk("mem_in", 32'(bus.mem_in), 32'(exp_in));
        chk("beta_cycles", 32'(bc), (ok && o == 2'b00) ? 32'd1 : 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("done_drop", 32'(bus.done), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit ok;
        int lat;
        int n;
        int extra;
        logic [1:0]   o;
        logic [M-1:0] d;
        logic [M-1:0] old;
        int a;

        // Reset state
        reset = 1'b1;
        bus.req = 1'b0; bus.op = 2'b00; bus.dato_in = '0;
        @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_errore", 32'(bus.errore), 32'd0);
        chk("rst_sp", 32'(bus.sp), 32'd0);
        chk("rst_d1", 32'(bus.dato_out1), 32'd0);
        chk("rst_d2", 32'(bus.dato_out2), 32'd0);
        chk("rst_ind1", 32'(bus.mem_ind1), 32'd0);
        chk("rst_ind2", 32'(bus.mem_ind2), 32'd0);
        chk("rst_in", 32'(bus.mem_in), 32'd0);
        chk("rst_beta", 32'(bus.mem_beta), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Pushes, then the read-type commands
        run_cmd(2'b00, 8'h11);
        run_cmd(2'b00, 8'h22);
        run_cmd(2'b00, 8'h33);
        run_cmd(2'b10, 8'h00);
        run_cmd(2'b01, 8'h00);
        run_cmd(2'b11, 8'h00);

        // Underflow cases
        run_cmd(2'b01, 8'h00);
        run_cmd(2'b00, 8'h44);
        run_cmd(2'b11, 8'h00);

        // Fill, overflow, then the top must be the fourth value
        run_cmd(2'b00, 8'h66);
        run_cmd(2'b00, 8'h77);
        run_cmd(2'b00, 8'h88);
        run_cmd(2'b00, 8'h55);
        run_cmd(2'b10, 8'h00);

        // req held high with alternating POP/PUSH: one done per command
        @(negedge clock);
        o = 2'b01; d = 8'($urandom_range(0, 255));
        model_cmd(o, d, ok, lat);
        bus.req = 1'b1; bus.op = o; bus.dato_in = d;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(posedge clock);
                n++;
                @(negedge clock);
            end while (bus.done !== 1'b1 && n < 20);
            chk("hold_spacing", 32'(n), 32'((i == 0 ? 0 : 1) + lat));
            chk("hold_errore", 32'(bus.errore), ok ? 32'd0 : 32'd1);
            chk("hold_sp", 32'(bus.sp), 32'(stk.size()));
            chk("hold_d1", 32'(bus.dato_out1), 32'(exp_d1));
            if (i < 5) begin
                o = (o == 2'b01) ? 2'b00 : 2'b01;
                d = 8'($urandom_range(0, 255));
                model_cmd(o, d, ok, lat);
                bus.op = o; bus.dato_in = d;
            end else begin
                bus.req = 1'b0;
            end
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) extra++;
        end
        chk("hold_extra_done", 32'(extra), 32'd0);

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            run_cmd(o, d);
        end

        // Reset while the write is pending must leave memory untouched
        if (stk.size() == N) run_cmd(2'b01, 8'h00);
        a   = stk.size();
        old = mem[a];
        d   = ~old;
        @(negedge clock);
        bus.req = 1'b1; bus.op = 2'b00; bus.dato_in = d;
        @(posedge clock);
        @(negedge clock);
        bus.req = 1'b0;
        chk("scrivi_beta", 32'(bus.mem_beta), 32'd1);
        chk("scrivi_ind1", 32'(bus.mem_ind1), 32'(a));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_beta", 32'(bus.mem_beta), 32'd0);
        chk("arst_sp", 32'(bus.sp), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(posedge clock);
        #1;
        chk("arst_mem_kept", 32'(mem[a]), 32'(old));
        @(negedge clock);
        reset = 1'b0;
        stk.delete();
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) extra++;
        end
        chk("arst_no_done", 32'(extra), 32'd0);
        chk("arst_sp_after", 32'(bus.sp), 32'd0);
        chk("arst_d1_after", 32'(bus.dato_out1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
